// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN weight-update datapath.
// Default sizing: 784 inputs per neuron, 16 output neurons, 24-bit unsigned
// weights, and the latency from the muxer's sweep index to its LUT deltas.
package snn_pkg;

    localparam int M       = 784;
    localparam int N       = 16;
    localparam int NW      = 4;
    localparam int W       = 24;
    localparam int IW      = 10;
    localparam int AW      = NW + IW;
    localparam int DEL_LAT = 2;

    localparam logic [W-1:0] WMAX = {W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wupd_state_t;

endpackage

// File: rtl/wupd_sat.sv
// Combinational saturating update: clamp(w + plus - minus, 0, WMAX).
// The sum is formed at W+2 signed bits, so neither the overflow of w + plus
// nor the underflow of the subtraction can wrap.
module wupd_sat #(
    parameter int           W    = 24,
    parameter logic [W-1:0] WMAX = {W{1'b1}}
) (
    input  logic [W-1:0] i_w,
    input  logic [W-1:0] i_plus,
    input  logic [W-1:0] i_minus,
    output logic [W-1:0] o_w
);

    logic signed [W+1:0] w_sum;
    logic signed [W+1:0] w_max_ext;

    assign w_sum     = $signed({2'b00, i_w}) + $signed({2'b00, i_plus}) - $signed({2'b00, i_minus});
    assign w_max_ext = $signed({2'b00, WMAX});

    // Clamp the extended sum to the representable weight range.
    always_comb begin
        o_w = w_sum[W-1:0];
        if (w_sum < 0) begin
            o_w = '0;
        end else if (w_sum > w_max_ext) begin
            o_w = WMAX;
        end
    end

endmodule

// File: rtl/weight_update_engine.sv
// Weight update engine. A winner pulse latches the winning output neuron;
// the muxer's ip_select sweep is then aged by DEL_LAT cycles to line up with
// the LUT deltas, and each index 1..M-1 of that neuron's weight row gets a
// read-modify-write: w <- clamp(w + del_w_plus - del_w_minus, 0, WMAX).
// Pipeline: capture (read strobe) -> read data -> registered write.
module weight_update_engine #(
    parameter int           M       = snn_pkg::M,
    parameter int           N       = snn_pkg::N,
    parameter int           NW      = snn_pkg::NW,
    parameter int           W       = snn_pkg::W,
    parameter logic [W-1:0] WMAX    = {W{1'b1}},
    parameter int           DEL_LAT = snn_pkg::DEL_LAT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    start_wch,
    input  logic [9:0]      ip_select,
    input  logic [W-1:0]    del_w_plus,
    input  logic [W-1:0]    del_w_minus,
    output logic            w_rd_en,
    output logic [NW+9:0]   w_rd_addr,
    input  logic [W-1:0]    w_rd_data,
    output logic            w_wr_en,
    output logic [NW+9:0]   w_wr_addr,
    output logic [W-1:0]    w_wr_data,
    output logic            busy,
    output logic            done,
    output logic            overrun
);

    import snn_pkg::*;

    localparam int IDXW  = 10;
    localparam int ADDRW = NW + IDXW;

    // Control state
    wupd_state_t       r_state;
    logic [NW-1:0]     r_winner;
    logic              r_busy;
    logic              r_done;
    logic              r_overrun;

    // Delay line aligning the sweep index with the LUT deltas
    logic [IDXW-1:0]   r_dl [DEL_LAT];
    logic [IDXW-1:0]   w_idx_d;

    // Capture / read stage
    logic              r_rd_en;
    logic [ADDRW-1:0]  r_rd_addr;
    logic [W-1:0]      r_p1_plus;
    logic [W-1:0]      r_p1_minus;

    // Read-data stage
    logic              r_v2;
    logic [ADDRW-1:0]  r_a2;
    logic [W-1:0]      r_p2_plus;
    logic [W-1:0]      r_p2_minus;

    // Write stage
    logic              r_wr_en;
    logic [ADDRW-1:0]  r_wr_addr;
    logic [W-1:0]      r_wr_data;

    logic [N-1:0]      w_first;
    logic [NW-1:0]     w_winner;
    logic [W-1:0]      w_sat;
    logic              w_accept;
    logic              w_capture;
    logic              w_last_cap;
    logic              w_last_write;

    assign w_idx_d      = r_dl[DEL_LAT-1];
    assign w_accept     = (r_state == ST_IDLE) && (|start_wch);
    assign w_capture    = (r_state == ST_SWEEP) && (w_idx_d != '0);
    assign w_last_cap   = w_capture && (w_idx_d == IDXW'(M - 1));
    // The final write is on the bus and nothing is left behind it.
    assign w_last_write = r_wr_en && !r_rd_en && !r_v2;

    // Isolate the lowest set bit of the winner vector.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_prio
            localparam logic [N-1:0] LOWER = {N{1'b1}} >> (N - gi);
            assign w_first[gi] = start_wch[gi] & ~(|(start_wch & LOWER));
        end
    endgenerate

    // Encode the isolated bit into a neuron number.
    always_comb begin
        w_winner = '0;
        for (int i = 0; i < N; i++) begin
            if (w_first[i]) begin
                w_winner = w_winner | NW'(i);
            end
        end
    end

    // Age ip_select by DEL_LAT cycles; cleared when a new sweep is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEL_LAT; i++) begin
                r_dl[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < DEL_LAT; i++) begin
                r_dl[i] <= '0;
            end
        end else if (r_state == ST_SWEEP) begin
            r_dl[0] <= ip_select;
            for (int i = 1; i < DEL_LAT; i++) begin
                r_dl[i] <= r_dl[i-1];
            end
        end
    end

    // Capture stage: issue the read and hold the matching deltas.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_p1_plus  <= '0;
            r_p1_minus <= '0;
        end else begin
            r_rd_en <= w_capture;
            if (w_capture) begin
                r_rd_addr  <= {r_winner, w_idx_d};
                r_p1_plus  <= del_w_plus;
                r_p1_minus <= del_w_minus;
            end
        end
    end

    // Read-data stage: carry address and deltas alongside the RAM latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2       <= 1'b0;
            r_a2       <= '0;
            r_p2_plus  <= '0;
            r_p2_minus <= '0;
        end else begin
            r_v2       <= r_rd_en;
            r_a2       <= r_rd_addr;
            r_p2_plus  <= r_p1_plus;
            r_p2_minus <= r_p1_minus;
        end
    end

    wupd_sat #(
        .W    (W),
        .WMAX (WMAX)
    ) u_sat (
        .i_w     (w_rd_data),
        .i_plus  (r_p2_plus),
        .i_minus (r_p2_minus),
        .o_w     (w_sat)
    );

    // Write stage: register the saturated weight and its address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= r_v2;
            if (r_v2) begin
                r_wr_addr <= r_a2;
                r_wr_data <= w_sat;
            end
        end
    end

    // Sweep control with registered busy / done / overrun flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_winner  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_winner <= w_winner;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    if (|start_wch) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_last_cap) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (|start_wch) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_last_write) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (|start_wch) begin
                        r_overrun <= 1'b1;
                    end
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_rd_en   = r_rd_en;
    assign w_rd_addr = r_rd_addr;
    assign w_wr_en   = r_wr_en;
    assign w_wr_addr = r_wr_addr;
    assign w_wr_data = r_wr_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_weight_update_engine.sv
// Bench for weight_update_engine: a muxer model drives ip_select with deltas
// DEL_LAT cycles later, a weight RAM model with registered read answers reads,
// and every write is checked against a scoreboard of expected
// {address, data, cycle} entries pushed when the index is driven.
module tb_weight_update_engine;

    import snn_pkg::*;

    localparam logic [W-1:0] TB_WMAX = {W{1'b1}};
    localparam int           NVEC    = 10;
    localparam int           LAT     = DEL_LAT + 3;

    typedef struct {
        logic [IW-1:0] idx;
        logic [W-1:0]  w0;
        logic [W-1:0]  plus;
        logic [W-1:0]  minus;
        logic [W-1:0]  exp_w;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        int            cyc;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    start_wch = '0;
    logic [IW-1:0]   ip_select = '0;
    logic [W-1:0]    del_w_plus = '0;
    logic [W-1:0]    del_w_minus = '0;
    logic            w_rd_en;
    logic [AW-1:0]   w_rd_addr;
    logic [W-1:0]    w_rd_data = '0;
    logic            w_wr_en;
    logic [AW-1:0]   w_wr_addr;
    logic [W-1:0]    w_wr_data;
    logic            busy;
    logic            done;
    logic            overrun;

    vec_t            vecs [NVEC];
    wr_t             sbq [$];
    logic [W-1:0]    mem     [0:(1<<AW)-1];
    logic [W-1:0]    exp_mem [0:(1<<AW)-1];
    logic            init_pending = 1'b1;
    logic [IW-1:0]   h1 = '0;
    logic [IW-1:0]   h2 = '0;
    int              cyc = 0;
    int              total = 0;
    int              bad = 0;

    weight_update_engine dut (
        .clk         (clk),
        .rst         (rst),
        .start_wch   (start_wch),
        .ip_select   (ip_select),
        .del_w_plus  (del_w_plus),
        .del_w_minus (del_w_minus),
        .w_rd_en     (w_rd_en),
        .w_rd_addr   (w_rd_addr),
        .w_rd_data   (w_rd_data),
        .w_wr_en     (w_wr_en),
        .w_wr_addr   (w_wr_addr),
        .w_wr_data   (w_wr_data),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int vec_of(input logic [IW-1:0] idx);
        for (int k = 0; k < NVEC; k++) begin
            if (vecs[k].idx == idx) return k;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] plus_of(input logic [IW-1:0] idx);
        int k;
        if (idx == '0) return '0;
        k = vec_of(idx);
        if (k >= 0) return vecs[k].plus;
        return W'(int'(idx) * 3);
    endfunction

    function automatic logic [W-1:0] minus_of(input logic [IW-1:0] idx);
        int k;
        if (idx == '0) return '0;
        k = vec_of(idx);
        if (k >= 0) return vecs[k].minus;
        return W'((int'(idx) % 11) * 40);
    endfunction

    function automatic logic [W-1:0] init_w(input logic [AW-1:0] a);
        int k;
        k = vec_of(a[IW-1:0]);
        if (a[AW-1:IW] == NW'(2) && a[IW-1:0] != '0 && k >= 0) return vecs[k].w0;
        return W'(int'(a[IW-1:0]) * 1000 + int'(a[AW-1:IW]) + 7);
    endfunction

    // Reference update: clamp(w + plus - minus, 0, 2^W-1) in wide integers.
    function automatic logic [W-1:0] model_upd(input logic [W-1:0] w, input logic [W-1:0] p,
                                               input logic [W-1:0] m);
        longint s;
        s = longint'(w) + longint'(p) - longint'(m);
        if (s < 0) return '0;
        if (s > longint'(TB_WMAX)) return TB_WMAX;
        return W'(s);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Weight RAM model: registered read, write on strobe.
    always @(posedge clk) begin
        if (init_pending) begin
            for (int i = 0; i < (1 << AW); i++) begin
                mem[i] <= init_w(AW'(i));
            end
        end else begin
            if (w_wr_en) mem[w_wr_addr] <= w_wr_data;
            if (w_rd_en) w_rd_data <= mem[w_rd_addr];
        end
    end

    // Scoreboard consumer: every write must match the next expected entry.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (w_wr_en === 1'b1) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL write_unexpected: got addr=%0h data=%0d cyc=%0d want no write",
                             w_wr_addr, w_wr_data, cyc);
                end else begin
                    e = sbq.pop_front();
                    if (w_wr_addr !== e.addr || w_wr_data !== e.data || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL write_check: got addr=%0h data=%0d cyc=%0d want addr=%0h data=%0d cyc=%0d",
                                 w_wr_addr, w_wr_data, cyc, e.addr, e.data, e.cyc);
                    end
                end
            end
        end
    end

    // One cycle of the muxer model: new index now, deltas for the index DEL_LAT cycles old.
    task automatic step(input logic [IW-1:0] sel, input logic [N-1:0] st, input logic r);
        @(posedge clk);
        #1;
        h2          = h1;
        h1          = ip_select;
        ip_select   = sel;
        start_wch   = st;
        rst         = r;
        del_w_plus  = plus_of(h2);
        del_w_minus = minus_of(h2);
        @(negedge clk);
    endtask

    task automatic run_sweep(input string tag, input logic [N-1:0] st, input logic [NW-1:0] win,
                             input int ovr_at, input int rst_at);
        int            done_cnt;
        int            done_at;
        int            busy_err;
        int            last;
        logic [IW-1:0] sel;
        logic [N-1:0]  stv;
        logic [AW-1:0] a;
        wr_t           e;
        done_cnt = 0;
        done_at  = -1;
        busy_err = 0;
        step('0, st, 1'b0);
        if (busy !== 1'b0) busy_err++;
        last = (rst_at > 0) ? rst_at - 1 : M + 8;
        for (int k = 1; k <= last; k++) begin
            sel = (k <= M - 1) ? IW'(k) : '0;
            stv = (k == ovr_at) ? N'(16'h0010) : '0;
            step(sel, stv, 1'b0);
            if (sel != '0) begin
                a          = {win, sel};
                e.addr     = a;
                e.data     = model_upd(exp_mem[a], plus_of(sel), minus_of(sel));
                e.cyc      = cyc + LAT;
                exp_mem[a] = e.data;
                sbq.push_back(e);
            end
            if (busy !== ((k >= 1 && k <= M + LAT - 1) ? 1'b1 : 1'b0)) busy_err++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
        end
        check({tag, "_busy_window_errors"}, 64'(busy_err), 64'd0);
        if (rst_at > 0) begin
            step('0, '0, 1'b1);
            check({tag, "_rst_busy"},    64'(busy),      64'd0);
            check({tag, "_rst_done"},    64'(done),      64'd0);
            check({tag, "_rst_overrun"}, 64'(overrun),   64'd0);
            check({tag, "_rst_rd_en"},   64'(w_rd_en),   64'd0);
            check({tag, "_rst_wr_en"},   64'(w_wr_en),   64'd0);
            check({tag, "_rst_rd_addr"}, 64'(w_rd_addr), 64'd0);
            check({tag, "_rst_wr_data"}, 64'(w_wr_data), 64'd0);
            sbq.delete();
            repeat (4) step('0, '0, 1'b0);
            check({tag, "_post_rst_busy"}, 64'(busy), 64'd0);
        end else begin
            check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
            check({tag, "_done_cycle"},  64'(done_at),  64'(M + LAT));
            check({tag, "_writes_left"}, 64'(sbq.size()), 64'd0);
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        vecs[0] = '{10'd1,   24'd1000,          24'd200,  24'd50,   24'd1150};
        vecs[1] = '{10'd2,   TB_WMAX - 24'd5,   24'd10,   24'd0,    TB_WMAX};
        vecs[2] = '{10'd3,   24'd3,             24'd0,    24'd7,    24'd0};
        vecs[3] = '{10'd4,   24'd100,           24'd50,   24'd150,  24'd0};
        vecs[4] = '{10'd5,   TB_WMAX - 24'd10,  24'd10,   24'd0,    TB_WMAX};
        vecs[5] = '{10'd6,   TB_WMAX,           24'd1,    24'd1,    TB_WMAX};
        vecs[6] = '{10'd400, 24'd123456,        24'd1000, 24'd456,  24'd124000};
        vecs[7] = '{10'd500, 24'd7,             24'd3,    24'd11,   24'd0};
        vecs[8] = '{10'd782, TB_WMAX,           24'd0,    TB_WMAX,  24'd0};
        vecs[9] = '{10'd783, 24'd5,             TB_WMAX,  24'd0,    TB_WMAX};
        for (int i = 0; i < (1 << AW); i++) begin
            exp_mem[i] = init_w(AW'(i));
        end

        repeat (2) @(posedge clk);
        #1;
        init_pending = 1'b0;
        @(negedge clk);
        check("reset_busy",    64'(busy),      64'd0);
        check("reset_done",    64'(done),      64'd0);
        check("reset_overrun", 64'(overrun),   64'd0);
        check("reset_rd_en",   64'(w_rd_en),   64'd0);
        check("reset_wr_en",   64'(w_wr_en),   64'd0);
        check("reset_rd_addr", 64'(w_rd_addr), 64'd0);
        check("reset_wr_addr", 64'(w_wr_addr), 64'd0);
        check("reset_wr_data", 64'(w_wr_data), 64'd0);
        repeat (3) step('0, '0, 1'b0);

        // Multi-hot start picks neuron 2; a second start mid-sweep is ignored.
        run_sweep("sweepA", N'(16'h0104), NW'(2), 100, 0);
        check("sweepA_overrun", 64'(overrun), 64'd1);
        for (int k = 0; k < NVEC; k++) begin
            a = {NW'(2), vecs[k].idx};
            check($sformatf("vec_idx%0d", vecs[k].idx), 64'(mem[a]), 64'(vecs[k].exp_w));
        end
        a = {NW'(2), IW'(0)};
        check("index0_untouched", 64'(mem[a]), 64'(W'(2 + 7)));
        repeat (3) step('0, '0, 1'b0);

        // Reset at cycle 300 of a sweep on neuron 3.
        run_sweep("sweepB", N'(16'h0008), NW'(3), 0, 300);

        // Fresh sweep after reset on neuron 5 with full timing.
        run_sweep("sweepC", N'(16'h0020), NW'(5), 0, 0);
        check("sweepC_overrun", 64'(overrun), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
